seg7_decimal_display: RTL and testbench

SEG7_DECIMAL_DISPLAY -- requirements
Module: seg7_decimal_display

---
 rtl/seg7_decimal_display.sv | 184 ++++++++++++++++++
 tb/tb_seg7_decimal_display.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_decimal_display.sv
// Purpose : converts a binary value (signed or unsigned) to decimal and drives DIGITS active-low 7-segment digits.
// Latency : seg/overflow update on the ENCODE edge, DATA_W+1 clocks after the accept edge; done pulses the cycle after.
// Backpr. : no queuing; update is ignored while busy=1 and must be re-presented once busy drops.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-low reset
//   value        number to display (two's complement when signed_mode=1)
//   signed_mode  1 = signed display, 0 = unsigned display
//   update       convert-and-display request, honoured only in IDLE
//   seg          DIGITS*7 active-low segments, digit i at [7i+6:7i], segment a at the MSB
//   busy         conversion in progress (SHIFT or ENCODE)
//   done         one-cycle pulse: seg/overflow just refreshed
//   overflow     last displayed value did not fit in the available digits
//
// Build option: define SEG7_LZB_EN for leading-zero blanking.

module seg7_decimal_display #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  signed_mode,
    input  logic                  update,
    output logic [DIGITS*7-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    // Enough BCD digits for any DATA_W-bit magnitude.
    localparam int BCD_D = (DATA_W * 3) / 10 + 1;
    // Zero-extended view wide enough for both the accumulator and the display,
    // so digit lookups never index past either.
    localparam int EXT_D = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);

    localparam logic [6:0] G_MINUS = 7'b1111110;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_E     = 7'b0110000;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0001100;
            default: glyph = G_BLANK;
        endcase
    endfunction

    function automatic logic [DIGITS*7-1:0] reset_pattern();
        logic [DIGITS*7-1:0] p;
        p = '1;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG7_LZB_EN
            p[7*i +: 7] = (i == 0) ? glyph(4'd0) : G_BLANK;
`else
            p[7*i +: 7] = (i == DIGITS - 1) ? G_BLANK : glyph(4'd0);
`endif
        end
        return p;
    endfunction

    localparam logic [DIGITS*7-1:0] SEG_RST = reset_pattern();

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-1:0]      mag;
    logic [4*BCD_D-1:0]     bcd, bcd_adj;
    logic [4*EXT_D-1:0]     bcd_ext;
    logic                   neg_q, smode_q;
    logic [DIGITS*7-1:0]    seg_enc;
    logic                   ovf_enc;

    assign busy = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (update) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_SHIFT) state_next = ENCODE;
            ENCODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- double-dabble step ----------------
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < BCD_D; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // ---------------- encode final BCD to glyphs ----------------
    always_comb begin : encode
        int avail;
        int msd;
        bcd_ext = (4*EXT_D)'(bcd);
        avail   = smode_q ? DIGITS - 1 : DIGITS;
        ovf_enc = 1'b0;
        msd     = 0;
        seg_enc = '1;
        for (int k = 0; k < EXT_D; k++) begin
            if (k >= avail && bcd_ext[4*k +: 4] != 4'd0) ovf_enc = 1'b1;
        end
        // Highest nonzero digit; only consulted when nothing overflowed, so it lies below avail.
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_ext[4*k +: 4] != 4'd0) msd = k;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_enc) begin
                seg_enc[7*i +: 7] = G_E;
            end else if (smode_q && i == DIGITS - 1) begin
                seg_enc[7*i +: 7] = neg_q ? G_MINUS : G_BLANK;
            end else begin
`ifdef SEG7_LZB_EN
                // msd >= 0, so digit 0 is never blanked.
                seg_enc[7*i +: 7] = (i > msd) ? G_BLANK : glyph(bcd_ext[4*i +: 4]);
`else
                seg_enc[7*i +: 7] = glyph(bcd_ext[4*i +: 4]);
`endif
            end
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg      <= SEG_RST;
            done     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            mag      <= '0;
            bcd      <= '0;
            neg_q    <= 1'b0;
            smode_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update) begin
                        smode_q <= signed_mode;
                        neg_q   <= signed_mode & value[DATA_W-1];
                        // Negating the most negative value wraps to 2^(DATA_W-1),
                        // which is exactly the magnitude when read as unsigned.
                        mag     <= (signed_mode & value[DATA_W-1]) ? (~value + DATA_W'(1)) : value;
                        bcd     <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    cnt        <= cnt + CNT_W'(1);
                end
                ENCODE: begin
                    seg      <= seg_enc;
                    overflow <= ovf_enc;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_decimal_display.sv
module tb_seg7_decimal_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        signed_mode;
    logic        update;
    logic [55:0] seg;
    logic        busy;
    logic        done;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_decimal_display #(.DATA_W(32), .DIGITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .signed_mode (signed_mode),
        .update      (update),
        .seg         (seg),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    // Expected displays written as 8 nibbles, digit 7 first:
    // 0-9 numerals, A = minus, B = blank, E = error glyph.
`ifdef SEG7_LZB_EN
    localparam logic [31:0] E_RST   = 32'hBBBBBBB0;
    localparam logic [31:0] E_1234567 = 32'hB1234567;
    localparam logic [31:0] E_42    = 32'hBBBBBB42;
    localparam logic [31:0] E_ZERO  = 32'hBBBBBBB0;
    localparam logic [31:0] E_NEG5  = 32'hABBBBBB5;
    localparam logic [31:0] E_POS7  = 32'hBBBBBBB7;
`else
    localparam logic [31:0] E_RST   = 32'hB0000000;
    localparam logic [31:0] E_1234567 = 32'h01234567;
    localparam logic [31:0] E_42    = 32'h00000042;
    localparam logic [31:0] E_ZERO  = 32'h00000000;
    localparam logic [31:0] E_NEG5  = 32'hA0000005;
    localparam logic [31:0] E_POS7  = 32'hB0000007;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0001100;
            4'hA:    glyph = 7'b1111110;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    function automatic logic [55:0] seg_of(input logic [31:0] nib);
        logic [55:0] s;
        s = '1;
        for (int i = 0; i < 8; i++) s[7*i +: 7] = glyph(nib[4*i +: 4]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full conversion: accept, latency, result, and done dropping afterwards.
    task automatic run(input string tag, input logic [31:0] v, input logic sm,
                       input logic [31:0] exp_nib, input logic exp_ovf);
        int n;
        @(negedge clk);
        value = v; signed_mode = sm; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'd33);
        check({tag, ".seg"}, 64'(seg), 64'(seg_of(exp_nib)));
        check({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        check({tag, ".done_clr"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        rst = 1'b0; value = '0; signed_mode = 1'b0; update = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.seg",  64'(seg), 64'(seg_of(E_RST)));
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.ovf",  64'(overflow), 64'd0);
        rst = 1'b1;

        run("u1234567",   32'd1234567,   1'b0, E_1234567,    1'b0);
        run("s-1234567",  32'hFFED2979,  1'b1, 32'hA1234567, 1'b0);
        run("u99999999",  32'd99999999,  1'b0, 32'h99999999, 1'b0);
        run("u100000000", 32'd100000000, 1'b0, 32'hEEEEEEEE, 1'b1);
        run("s80000000",  32'h80000000,  1'b1, 32'hEEEEEEEE, 1'b1);

        // Abort on the 10th SHIFT cycle, with overflow still set from the run above.
        @(negedge clk);
        value = 32'd1234567; signed_mode = 1'b0; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.seg",  64'(seg), 64'(seg_of(E_RST)));
        check("abort.ovf",  64'(overflow), 64'd0);
        rst = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort.no_done", 64'(dones), 64'd0);
        run("post_abort", 32'd42, 1'b0, E_42, 1'b0);

        run("s9999999", 32'd9999999,  1'b1, 32'hB9999999, 1'b0);
        run("u0",       32'd0,        1'b0, E_ZERO,       1'b0);
        run("s-5",      32'hFFFFFFFB, 1'b1, E_NEG5,       1'b0);
        run("s7",       32'd7,        1'b1, E_POS7,       1'b0);
        run("uFFFFFFFF",32'hFFFFFFFF, 1'b0, 32'hEEEEEEEE, 1'b1);

        // Second update 5 cycles after accept must be ignored.
        @(negedge clk);
        value = 32'd1234567; signed_mode = 1'b0; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        value = 32'd42; update = 1'b1;
        @(negedge clk);
        n++;
        update = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ignore.latency", 64'(n), 64'd33);
        check("ignore.seg", 64'(seg), 64'(seg_of(E_1234567)));
        @(negedge clk);
        check("ignore.idle", 64'({busy, done}), 64'd0);
        run("after_ignore", 32'd42, 1'b0, E_42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
